// File: rtl/hilo_mdu.sv
// hilo_mdu: MIPS HI/LO multiply/divide unit; results land N cycles after start with MDU_MULTICYCLE_EN, else at the start edge.
// No backpressure: busy lets the hazard unit stall HI/LO users; ops arriving while busy are dropped.
module hilo_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] hiloop,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [10:0] Hilo_mult  = 11'h001;
    localparam logic [10:0] Hilo_multu = 11'h002;
    localparam logic [10:0] Hilo_div   = 11'h004;
    localparam logic [10:0] Hilo_divu  = 11'h008;
    localparam logic [10:0] Hilo_ToHi  = 11'h010;
    localparam logic [10:0] Hilo_ToLo  = 11'h020;

`ifdef MDU_MULTICYCLE_EN
    localparam bit MULTICYCLE = 1'b1;
`else
    localparam bit MULTICYCLE = 1'b0;
`endif

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        op_div_zero_q, op_div_zero_d;

    logic        is_mult, is_div, is_signed, div_zero, start_ok;
    logic [63:0] op_a_ext, op_b_ext, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [31:0] new_hi, new_lo;
    logic [3:0]  cnt_load;

    // Result datapath: evaluated combinationally from the operands at the start edge.
    always_comb begin
        is_mult   = (hiloop == Hilo_mult) || (hiloop == Hilo_multu);
        is_div    = (hiloop == Hilo_div)  || (hiloop == Hilo_divu);
        is_signed = (hiloop == Hilo_mult) || (hiloop == Hilo_div);
        div_zero  = (rt == 32'd0);

        op_a_ext = is_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
        op_b_ext = is_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
        product  = op_a_ext * op_b_ext;

        // Signed divide via magnitudes; INT_MIN / -1 falls out as 0x80000000 rem 0.
        a_neg  = is_signed & rs[31];
        b_neg  = is_signed & rt[31];
        a_mag  = a_neg ? -rs : rs;
        b_mag  = b_neg ? -rt : rt;
        b_safe = div_zero ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;

        new_hi = is_mult ? product[63:32] : rem;
        new_lo = is_mult ? product[31:0]  : quot;

        if (!MULTICYCLE) begin
            cnt_load = 4'd0;
        end else if (is_mult) begin
            cnt_load = 4'(MULT_CYCLES);
        end else begin
            cnt_load = 4'(DIV_CYCLES);
        end

        start_ok = start & ~busy_q & (is_mult | is_div);
    end

    always_comb begin
        hi_d          = hi_q;
        lo_d          = lo_q;
        res_hi_d      = res_hi_q;
        res_lo_d      = res_lo_q;
        cnt_d         = cnt_q;
        op_div_zero_d = op_div_zero_q;

        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && !op_div_zero_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end else if (start_ok) begin
            res_hi_d      = new_hi;
            res_lo_d      = new_lo;
            op_div_zero_d = is_div & div_zero;
            cnt_d         = cnt_load;
            // Zero-latency build commits at the start edge itself.
            if (cnt_load == 4'd0 && !(is_div && div_zero)) begin
                hi_d = new_hi;
                lo_d = new_lo;
            end
        end else if (hiloop == Hilo_ToHi) begin
            hi_d = rs;
        end else if (hiloop == Hilo_ToLo) begin
            lo_d = rs;
        end

        busy_d = (cnt_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            res_hi_q      <= 32'd0;
            res_lo_q      <= 32'd0;
            cnt_q         <= 4'd0;
            busy_q        <= 1'b0;
            op_div_zero_q <= 1'b0;
        end else begin
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            res_hi_q      <= res_hi_d;
            res_lo_q      <= res_lo_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            op_div_zero_q <= op_div_zero_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomized scoreboard bench for hilo_mdu against an arithmetic reference model.
module tb_hilo_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [10:0] OP_NONE  = 11'h000;
    localparam logic [10:0] OP_MULT  = 11'h001;
    localparam logic [10:0] OP_MULTU = 11'h002;
    localparam logic [10:0] OP_DIV   = 11'h004;
    localparam logic [10:0] OP_DIVU  = 11'h008;
    localparam logic [10:0] OP_TOHI  = 11'h010;
    localparam logic [10:0] OP_TOLO  = 11'h020;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] hiloop;
    logic [31:0] rs, rt;
    logic        busy;
    logic [31:0] hi, lo;

    hilo_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .hiloop(hiloop),
        .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        int          edge_no;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: architectural HI/LO plus one pending operation.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_inflight, p_zero;
    int          done_at, edge_n;

    function automatic bit is_md(input logic [10:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic int latency(input logic [10:0] op);
`ifdef MDU_MULTICYCLE_EN
        return (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
`else
        return (op == OP_NONE) ? -1 : 0;
`endif
    endfunction

    // Returns {HI, LO}; 64-bit arithmetic keeps INT_MIN / -1 well defined.
    function automatic logic [63:0] ref_result(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (op)
            OP_MULT:  begin p = sa * sb; res = p; end
            OP_MULTU: res = {32'd0, a} * {32'd0, b};
            OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            OP_DIVU:  if (b != 0) begin q = longint'({32'd0, a}) / longint'({32'd0, b});
                                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                                        res = {r[31:0], q[31:0]}; end
            default:  res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic model_edge(input logic st, input logic [10:0] op, input logic [31:0] a, input logic [31:0] b, input logic rn);
        if (!rn) begin
            m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_inflight = 0; p_zero = 0;
            return;
        end
        if (m_inflight) begin
            if (edge_n == done_at) begin
                if (!p_zero) begin m_hi = p_hi; m_lo = p_lo; end
                m_inflight = 0;
            end
        end else if (st && is_md(op)) begin
            {p_hi, p_lo} = ref_result(op, a, b);
            p_zero = (op == OP_DIV || op == OP_DIVU) && b == 0;
            if (latency(op) == 0) begin
                if (!p_zero) begin m_hi = p_hi; m_lo = p_lo; end
            end else begin
                m_inflight = 1;
                done_at = edge_n + latency(op);
            end
        end else if (op == OP_TOHI) begin
            m_hi = a;
        end else if (op == OP_TOLO) begin
            m_lo = a;
        end
    endtask

    task automatic step(input logic st, input logic [10:0] op, input logic [31:0] a, input logic [31:0] b, input logic rn);
        exp_t e;
        start = st; hiloop = op; rs = a; rt = b; reset = rn;
        @(posedge clk);
        edge_n++;
        model_edge(st, op, a, b, rn);
        e.busy = m_inflight; e.hi = m_hi; e.lo = m_lo; e.edge_no = edge_n;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic idle();
        step(1'b0, OP_NONE, $urandom, $urandom, 1'b1);
    endtask

    task automatic run_op(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        step(1'b1, op, a, b, 1'b1);
        for (int k = 0; k < 20 && m_inflight; k++) idle();
        idle();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int e_no);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s edge %0d: got %h expected %h", name, e_no, act, exp);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("busy", {31'd0, busy}, {31'd0, e.busy}, e.edge_no);
            chk("hi", hi, e.hi, e.edge_no);
            chk("lo", lo, e.lo, e.edge_no);
        end
    end

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [10:0] rand_md();
        case ($urandom_range(0, 3))
            0: return OP_MULT;
            1: return OP_MULTU;
            2: return OP_DIV;
            default: return OP_DIVU;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_inflight = 0; p_zero = 0;
        done_at = 0; edge_n = 0;
        start = 0; hiloop = OP_NONE; rs = 0; rt = 0; reset = 0;

        step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        idle();

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        step(1'b0, OP_TOHI, 32'h11, 32'd0, 1'b1);
        step(1'b0, OP_TOLO, 32'h22, 32'd0, 1'b1);
        run_op(OP_DIVU,  32'd1234, 32'd0);
        step(1'b0, OP_TOHI, 32'hABCD_0000, 32'd0, 1'b1);
        step(1'b0, OP_TOLO, 32'h0000_1234, 32'd0, 1'b1);
        idle();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);

        // Reset lands during the fourth busy cycle of a divide.
        step(1'b1, OP_DIV, 32'd100, 32'd7, 1'b1);
        idle(); idle(); idle();
        step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < 12; k++) idle();

        // Operations issued while busy must be dropped.
        step(1'b1, OP_MULTU, 32'd3, 32'd4, 1'b1);
        step(1'b1, OP_MULT, 32'd9, 32'd9, 1'b1);
        step(1'b0, OP_TOHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        for (int k = 0; k < 12; k++) idle();

        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: step(1'b1, rand_md(), rand_opnd(), rand_opnd(), 1'b1);
                4: step(1'b0, OP_TOHI, $urandom, $urandom, 1'b1);
                5: step(1'b0, OP_TOLO, $urandom, $urandom, 1'b1);
                6: step(1'b0, rand_md(), rand_opnd(), rand_opnd(), 1'b1);
                7, 8: idle();
                default: step(1'b0, OP_NONE, $urandom, $urandom, ($urandom_range(0, 9) != 0));
            endcase
        end
        for (int k = 0; k < 20; k++) idle();

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multiply/divide unit with the architectural HI/LO register pair, in the E stage of the P6 pipeline. It is the responder for the decoder's `E_start`/`hiloop` outputs. It runs `mult`/`multu`/`div`/`divu` as fixed-latency multicycle operations and applies `mthi`/`mtlo` immediately. It exports `busy`, which the hazard unit uses to stall HI/LO consumers in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range 1..15.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; `reset==0` at an edge clears all state.
- `start`  in  1: from the decoder's `E_start`; high only for mult/multu/div/divu in E.
- `hiloop`  in  11: operation code; uses the shared constants `Hilo_mult`, `Hilo_multu`, `Hilo_div`, `Hilo_divu`, `Hilo_ToHi` and `Hilo_ToLo`; 0 = none.
- `rs`  in  32: forwarded GPR[rs]; dividend, multiplicand, or mthi/mtlo source.
- `rt`  in  32: forwarded GPR[rt]; divisor or multiplier.
- `busy`  out  1: registered; high while an operation is in flight.
- `hi`  out  32: HI register value.
- `lo`  out  32: LO register value.

## Operation
- State:
  - `hi`, `lo` registers.
  - `cnt` (4 bits) counter.
  - pending result registers `res_hi`, `res_lo`.
  - `op_div_zero` flag.
- Reset (`reset==0` at an edge):
  - `hi=0`, `lo=0`, `cnt=0`, `busy=0`, pending registers cleared.
  - Any operation in flight is aborted.
- Start edge, when `start==1`, `busy==0` and `hiloop` is mult/multu/div/divu:
  - compute the result from `rs`/`rt` and store it in `res_hi`/`res_lo`;
  - load `cnt` with the matching cycle count.
- `mult`: signed 32x32 -> 64-bit; HI = product[63:32], LO = product[31:0].
- `multu`: same as `mult`, unsigned.
- `div`: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- `divu`: unsigned; LO = quotient, HI = remainder.
- Divisor zero (div/divu): `op_div_zero` is set; the operation still occupies `busy` for its full count, and HI/LO are left unchanged at completion.
- Completion: each edge with `cnt!=0` decrements `cnt`. On the 1->0 transition, `hi<=res_hi` and `lo<=res_lo` unless `op_div_zero` is set.
- `mthi`/`mtlo`: when `hiloop` is `Hilo_ToHi`/`Hilo_ToLo` and `busy==0`, `hi<=rs` (or `lo<=rs`) at that edge. No busy period.
- Anything arriving while `busy==1` (a `start` or a to-HI/LO op) is ignored. The hazard unit guarantees this never happens in legal operation.
- `hiloop` with `start==0` and not a to-HI/LO code: no action.

## Timing
- Start accepted at edge T:
  - `busy` is high from after T through the edge at T+N; N = `MULT_CYCLES` or `DIV_CYCLES`.
  - The new `hi`/`lo` are visible after edge T+N, in the same cycle `busy` falls.
- Back-to-back: a second `start` is accepted in the first cycle with `busy==0`.
- `mthi`/`mtlo` at edge T: value visible after T.
- `hi`/`lo` are plain register outputs, with no combinational path from inputs.
- The hazard unit stalls a D-stage HI/LO user whenever `busy | start`.

## Configuration
- `MDU_MULTICYCLE_EN` defined:
  - latency counting as above.
- `MDU_MULTICYCLE_EN` undefined:
  - the result is written to `hi`/`lo` at the start edge itself;
  - `cnt` and `busy` are tied to 0;
  - both parameters are ignored;
  - divide-by-zero still leaves HI/LO unchanged.

## Test plan
- `mult`, rs=0xFFFFFFFD (-3), rt=5 -> `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- `multu`, rs=0xFFFFFFFF, rt=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- `div`, rs=0xFFFFFFF9 (-7), rt=2 -> `busy` high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `divu`, rt=0, with prior HI=0x11, LO=0x22 -> 10 busy cycles; then HI/LO still 0x11/0x22.
- `mthi` rs=0xABCD0000 then `mtlo` rs=0x1234 on consecutive cycles -> HI=0xABCD0000 and LO=0x1234, each one cycle after its edge, `busy` never high.
- `div` started, `reset=0` on the 4th busy cycle -> next cycle `busy=0`, HI=LO=0, and no late write-back afterwards.
